gam_stream_sequencer: RTL and testbench
=======================================

GAM_STREAM_SEQUENCER -- requirements
Module: gam_stream_sequencer

Interface
REQ-001 Parameter VEC_W, default 64: node vector width in bits, which is the width of in_vec, x and recall_pattern.
REQ-002 Parameter CLASS_W, default 32: class label width in bits, which is the width of in_class, c and recall_class.
REQ-003 Parameter OUT_DEPTH, default 4: result FIFO depth; power of two, 2..64.
REQ-004 Parameter CNT_W, default 16: width of the beat counters.
REQ-005 Port clk  in  1  sole clock; all logic is on the posedge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Ports in_valid in 1, in_ready out 1: input beat handshake.
REQ-008 Ports in_vec in VEC_W, in_class in CLASS_W, in_ctrl in 2 (bit0 learning_done, bit1 recall), in_eom in 1: input beat payload.
REQ-009 Ports x out VEC_W, c out CLASS_W, learning_done out 1, learning_recall out 1 (0=LEARNING, 1=RECALL), mem_load out 1: drive the memory layer and the recall unit.
REQ-010 Port mem_ready in 1: memory layer status, 1=READY, 0=IDLE/busy.
REQ-011 Ports recall_valid in 1, recall_pattern in VEC_W, recall_class in CLASS_W: recall unit result.
REQ-012 Ports out_valid out 1, out_ready in 1, out_data out CLASS_W+VEC_W ({class,pattern}), out_last out 1: result stream.
REQ-013 Ports learn_count out CNT_W, recall_count out CNT_W, done out 1, error out 1: status.

Function
REQ-014 The block SHALL implement the states LEARN, LWAIT, SWITCH, RECALL, RWAIT, DRAIN and DONE.
REQ-015 LEARN: in_ready=mem_ready; an accepted beat (valid&ready) SHALL register in_vec->x and in_class->c, pulse mem_load for 1 cycle, increment learn_count, and go to LWAIT.
REQ-016 LWAIT: in_ready=0; return to LEARN on the first cycle mem_ready=1 with mem_load=0, i.e. no earlier than 2 cycles after acceptance.
REQ-017 A learning beat with in_ctrl[0]=1 SHALL set learning_done=1; after its LWAIT the FSM goes to SWITCH instead of LEARN.
REQ-018 SWITCH: in_ready=1; x, c and counters hold; an accepted beat with in_ctrl==2'b11 SHALL set learning_recall=1 and go to RECALL.
REQ-019 SWITCH: an accepted beat with any other in_ctrl value SHALL be discarded and the FSM SHALL stay in SWITCH.
REQ-020 RECALL: in_ready=1 only when FIFO occupancy < OUT_DEPTH; an accepted beat SHALL register x, leave c unchanged, increment recall_count, latch in_eom, and go to RWAIT.
REQ-021 RWAIT: in_ready=0; on the first cycle recall_valid=1, push {recall_class, recall_pattern, eom_latched} into the FIFO.
REQ-022 After the RWAIT push, the FSM SHALL go to DRAIN if eom_latched, else to RECALL.
REQ-023 The FIFO SHALL be first-word-fall-through: out_valid=!empty, out_data/out_last come from the head entry, pop on out_valid&out_ready.
REQ-024 A simultaneous push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-025 The FIFO read and write pointers SHALL wrap modulo OUT_DEPTH.
REQ-026 Back-pressure (out_ready=0) SHALL never drop or reorder entries.
REQ-027 DRAIN: in_ready=0; go to DONE on the cycle the entry with last=1 is popped.
REQ-028 DONE: done=1 sticky, in_ready=0, x/c/learning_done/learning_recall hold, until reset.
REQ-029 in_eom=1 on a LEARN or SWITCH beat SHALL set error=1 (sticky) and go to DONE with no FIFO push.
REQ-030 Counters SHALL saturate at 2^CNT_W-1; they never wrap.
REQ-031 mem_load SHALL be asserted only in the cycle after a LEARN acceptance.
REQ-032 learning_recall SHALL never return from 1 to 0 except by reset.

Reset
REQ-033 On reset=1 at a posedge, the block SHALL enter state LEARN.
REQ-034 On reset, x=0, c=0, learning_done=0, learning_recall=0 and mem_load=0.
REQ-035 On reset, the FIFO SHALL be emptied (out_valid=0, out_last=0), learn_count=0, recall_count=0, done=0 and error=0.
REQ-036 in_ready SHALL be 0 during the reset cycle.
REQ-037 Reset asserted mid-LWAIT, RWAIT or DRAIN SHALL abort the operation and discard FIFO contents; the next cycle behaves as post-reset LEARN.

Verification
REQ-038 3 learning beats (last with in_ctrl=01), mem_ready low 2 cycles after each load -> 3 mem_load pulses, learn_count=3, learning_done=1, state SWITCH.
REQ-039 In SWITCH, send in_ctrl=01 then 11 -> first beat ignored, learning_recall=1 after the second, x unchanged.
REQ-040 5 recall beats, OUT_DEPTH=4, out_ready=0 -> in_ready drops after 4 results; raise out_ready -> 5 ordered outputs, out_last only on the 5th, done=1.
REQ-041 out_ready toggling every cycle during recall -> no loss or duplication; recall_count equals output count.
REQ-042 Learning beat with in_eom=1 -> error=1, done=1, out_valid stays 0.
REQ-043 Reset asserted with 2 FIFO entries pending -> out_valid=0 next cycle, counters=0, state LEARN.

Source files
------------

// File: rtl/gam_stream_sequencer_if.sv
// Stream sequencer bundle: input beats, memory-layer load/status, recall-unit
// result, result stream and status. Clock and reset are not part of the bundle.
//   slave  : sequencer view (consumes input beats, produces results/status)
//   master : environment view (drives beats, memory status, recall results)
interface gam_stream_sequencer_if #(
  parameter int VEC_W   = 64,
  parameter int CLASS_W = 32,
  parameter int CNT_W   = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [VEC_W-1:0]         in_vec;
  logic [CLASS_W-1:0]       in_class;
  logic [1:0]               in_ctrl;
  logic                     in_eom;
  logic [VEC_W-1:0]         x;
  logic [CLASS_W-1:0]       c;
  logic                     learning_done;
  logic                     learning_recall;
  logic                     mem_load;
  logic                     mem_ready;
  logic                     recall_valid;
  logic [VEC_W-1:0]         recall_pattern;
  logic [CLASS_W-1:0]       recall_class;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W+VEC_W-1:0] out_data;
  logic                     out_last;
  logic [CNT_W-1:0]         learn_count;
  logic [CNT_W-1:0]         recall_count;
  logic                     done;
  logic                     error;

  modport slave (
    input  in_valid, in_vec, in_class, in_ctrl, in_eom, mem_ready,
           recall_valid, recall_pattern, recall_class, out_ready,
    output in_ready, x, c, learning_done, learning_recall, mem_load,
           out_valid, out_data, out_last, learn_count, recall_count, done, error
  );

  modport master (
    output in_valid, in_vec, in_class, in_ctrl, in_eom, mem_ready,
           recall_valid, recall_pattern, recall_class, out_ready,
    input  in_ready, x, c, learning_done, learning_recall, mem_load,
           out_valid, out_data, out_last, learn_count, recall_count, done, error
  );
endinterface

// File: rtl/gam_stream_sequencer.sv
// Sequences a beat stream through a learning phase (loading the memory layer)
// and a recall phase (collecting recall-unit results into an output FIFO).
// Ports:
//   clk   - sole clock, posedge
//   reset - synchronous, active-high
//   bus   - gam_stream_sequencer_if.slave: input beats, x/c/mem_load to the
//           memory layer, recall results in, FWFT result stream out, status
//
// state  | meaning
// LEARN  | accept learning beats while the memory layer is ready
// LWAIT  | memory layer absorbing the last load
// SWITCH | waiting for the ctrl=11 beat that starts recall
// RECALL | accept recall beats while the result FIFO has room
// RWAIT  | waiting for the recall unit result
// DRAIN  | emptying the FIFO until the last-flagged entry leaves
// DONE   | finished (or errored); holds until reset
module gam_stream_sequencer #(
  parameter int VEC_W     = 64,
  parameter int CLASS_W   = 32,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  gam_stream_sequencer_if.slave bus
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int EW = CLASS_W + VEC_W + 1;
  localparam logic [AW:0] FULL = (AW+1)'(OUT_DEPTH);

  typedef enum logic [2:0] {
    S_LEARN, S_LWAIT, S_SWITCH, S_RECALL, S_RWAIT, S_DRAIN, S_DONE
  } state_t;

  state_t               r_state;
  logic [VEC_W-1:0]     r_x;
  logic [CLASS_W-1:0]   r_c;
  logic                 r_learning_done;
  logic                 r_learning_recall;
  logic                 r_mem_load;
  logic                 r_eom;
  logic [CNT_W-1:0]     r_learn_count;
  logic [CNT_W-1:0]     r_recall_count;
  logic                 r_done;
  logic                 r_error;

  // Entry layout {class, pattern, last}
  logic [EW-1:0]        r_fifo [OUT_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [EW-1:0]        w_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign w_empty  = (r_count == '0);
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_pop    = !w_empty && bus.out_ready;
  // Room is guaranteed: RECALL only accepts when occupancy < depth.
  assign w_push   = (r_state == S_RWAIT) && bus.recall_valid;
  assign w_accept = bus.in_valid && w_in_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_LEARN:  w_in_ready = bus.mem_ready;
      S_SWITCH: w_in_ready = 1'b1;
      S_RECALL: w_in_ready = (r_count < FULL);
      default:  w_in_ready = 1'b0;
    endcase
    if (reset) w_in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_LEARN;
      r_x               <= '0;
      r_c               <= '0;
      r_learning_done   <= 1'b0;
      r_learning_recall <= 1'b0;
      r_mem_load        <= 1'b0;
      r_eom             <= 1'b0;
      r_learn_count     <= '0;
      r_recall_count    <= '0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
    end else begin
      r_mem_load <= 1'b0;
      case (r_state)
        S_LEARN: begin
          if (w_accept) begin
            if (bus.in_eom) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_x           <= bus.in_vec;
              r_c           <= bus.in_class;
              r_mem_load    <= 1'b1;
              r_learn_count <= sat_inc(r_learn_count);
              if (bus.in_ctrl[0]) r_learning_done <= 1'b1;
              r_state       <= S_LWAIT;
            end
          end
        end
        S_LWAIT: begin
          // mem_ready may still show the pre-load status while mem_load is high.
          if (bus.mem_ready && !r_mem_load)
            r_state <= r_learning_done ? S_SWITCH : S_LEARN;
        end
        S_SWITCH: begin
          if (w_accept) begin
            if (bus.in_eom) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (bus.in_ctrl == 2'b11) begin
              r_learning_recall <= 1'b1;
              r_state           <= S_RECALL;
            end
          end
        end
        S_RECALL: begin
          if (w_accept) begin
            r_x            <= bus.in_vec;
            r_recall_count <= sat_inc(r_recall_count);
            r_eom          <= bus.in_eom;
            r_state        <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.recall_valid) r_state <= r_eom ? S_DRAIN : S_RECALL;
        end
        S_DRAIN: begin
          if (w_pop && w_head[0]) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: r_state <= S_LEARN;
      endcase
    end
  end

  // Pointers wrap naturally: depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {bus.recall_class, bus.recall_pattern, r_eom};
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.x               = r_x;
  assign bus.c               = r_c;
  assign bus.learning_done   = r_learning_done;
  assign bus.learning_recall = r_learning_recall;
  assign bus.mem_load        = r_mem_load;
  assign bus.out_valid       = !w_empty;
  assign bus.out_data        = w_head[EW-1:1];
  assign bus.out_last        = !w_empty && w_head[0];
  assign bus.learn_count     = r_learn_count;
  assign bus.recall_count    = r_recall_count;
  assign bus.done            = r_done;
  assign bus.error           = r_error;
endmodule

// File: tb/tb_gam_stream_sequencer.sv
module tb_gam_stream_sequencer;
  logic clk;
  logic reset;

  gam_stream_sequencer_if #(.VEC_W(64), .CLASS_W(32), .CNT_W(16)) bus ();

  gam_stream_sequencer #(.VEC_W(64), .CLASS_W(32), .OUT_DEPTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctrl;
    logic [63:0] vec;
    logic [31:0] cls;
    logic [15:0] exp_lc;
    logic        exp_ld;
    logic        exp_lr;
    logic        exp_ml;
    logic [63:0] exp_x;
    logic [31:0] exp_c;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int mload_cnt = 0;
  int pop_cnt = 0;
  int mem_lat = 2;
  int mem_busy = 0;
  bit mem_force_low = 0;
  int out_mode = 0;
  logic [96:0] exp_q [$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.recall_valid = 1'b0;
    @(negedge clk);
    check("in_ready_during_reset", bus.in_ready, 0);
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [63:0] v, input logic [31:0] cl, input logic [1:0] ct,
                           input logic eom, output bit ok);
    int n;
    n = 0;
    ok = 0;
    bus.in_vec = v;
    bus.in_class = cl;
    bus.in_ctrl = ct;
    bus.in_eom = eom;
    bus.in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: beat ctrl %0b not accepted within %0d cycles", ct, n);
    end
  endtask

  // Recall unit stand-in: answers with a pattern/class derived from the query.
  task automatic recall_respond(input logic [63:0] v, input logic eom, input int lat);
    logic [63:0] pat;
    logic [31:0] cls;
    repeat (lat) tick();
    pat = ~v;
    cls = v[31:0] ^ 32'h5A5A_0F0F;
    exp_q.push_back({cls, pat, eom});
    bus.recall_pattern = pat;
    bus.recall_class = cls;
    bus.recall_valid = 1'b1;
    tick();
    bus.recall_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!bus.done && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", bus.done, 1);
    tick();
  endtask

  task automatic run_episode(input int nl, input int ns, input int nr, input int mode);
    logic [63:0] v;
    logic [63:0] last_v;
    logic [31:0] cl;
    logic [31:0] last_cls;
    logic [1:0]  ct;
    bit ok;
    int mb;
    int pb;
    last_v = '0;
    last_cls = '0;
    do_reset();
    mb = mload_cnt;
    pb = pop_cnt;
    out_mode = mode;
    for (int i = 0; i < nl; i++) begin
      v = {$urandom, $urandom};
      cl = $urandom;
      mem_lat = $urandom_range(0, 3);
      send_beat(v, cl, (i == nl - 1) ? 2'b01 : 2'b00, 1'b0, ok);
      last_cls = cl;
    end
    for (int j = 0; j < ns; j++) begin
      ct = 2'($urandom_range(0, 2));
      send_beat({$urandom, $urandom}, $urandom, ct, 1'b0, ok);
    end
    send_beat({$urandom, $urandom}, $urandom, 2'b11, 1'b0, ok);
    for (int k = 0; k < nr; k++) begin
      v = {$urandom, $urandom};
      ct = 2'($urandom);
      send_beat(v, $urandom, ct, (k == nr - 1), ok);
      recall_respond(v, (k == nr - 1), $urandom_range(0, 3));
      last_v = v;
    end
    wait_done(400);
    check("ep_learn_count", bus.learn_count, nl);
    check("ep_recall_count", bus.recall_count, nr);
    check("ep_outputs", pop_cnt - pb, nr);
    check("ep_mem_loads", mload_cnt - mb, nl);
    check("ep_flags", {bus.learning_done, bus.learning_recall, bus.error}, 3'b110);
    check("ep_x_last_recall", bus.x, last_v);
    check("ep_c_last_learn", bus.c, last_cls);
    check("ep_fifo_empty", bus.out_valid, 0);
  endtask

  initial begin
    beat_t tbl [7];
    logic [63:0] v;
    bit ok;
    int n;
    int bad;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    bus.in_class = '0;
    bus.in_ctrl = '0;
    bus.in_eom = 1'b0;
    bus.recall_valid = 1'b0;
    bus.recall_pattern = '0;
    bus.recall_class = '0;

    fork
      forever begin
        tick();
        if (reset) begin
          bus.mem_ready = 1'b1;
          mem_busy = 0;
        end else if (mem_force_low) begin
          bus.mem_ready = 1'b0;
        end else if (bus.mem_load && mem_lat > 0) begin
          bus.mem_ready = 1'b0;
          mem_busy = mem_lat;
        end else if (mem_busy > 0) begin
          mem_busy--;
          if (mem_busy == 0) bus.mem_ready = 1'b1;
        end else begin
          bus.mem_ready = 1'b1;
        end
        case (out_mode)
          0: bus.out_ready = 1'b0;
          1: bus.out_ready = 1'b1;
          2: bus.out_ready = 1'($urandom_range(0, 1));
          default: bus.out_ready = ~bus.out_ready;
        endcase
      end
      forever begin
        @(negedge clk);
        if (!reset && bus.mem_load) mload_cnt++;
        if (!reset && bus.out_valid && bus.out_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL pop_extra: got %0h with no result outstanding", {bus.out_data, bus.out_last});
          end else begin
            check("pop_data", {bus.out_data, bus.out_last}, exp_q.pop_front());
          end
        end
      end
    join_none

    tbl[0] = '{2'b00, 64'h1111_0000_1111_0001, 32'hA1, 16'd1, 1'b0, 1'b0, 1'b1, 64'h1111_0000_1111_0001, 32'hA1};
    tbl[1] = '{2'b00, 64'h2222_0000_2222_0002, 32'hA2, 16'd2, 1'b0, 1'b0, 1'b1, 64'h2222_0000_2222_0002, 32'hA2};
    tbl[2] = '{2'b01, 64'h3333_0000_3333_0003, 32'hA3, 16'd3, 1'b1, 1'b0, 1'b1, 64'h3333_0000_3333_0003, 32'hA3};
    tbl[3] = '{2'b01, 64'h4444_0000_4444_0004, 32'hB4, 16'd3, 1'b1, 1'b0, 1'b0, 64'h3333_0000_3333_0003, 32'hA3};
    tbl[4] = '{2'b10, 64'h5555_0000_5555_0005, 32'hB5, 16'd3, 1'b1, 1'b0, 1'b0, 64'h3333_0000_3333_0003, 32'hA3};
    tbl[5] = '{2'b00, 64'h6666_0000_6666_0006, 32'hB6, 16'd3, 1'b1, 1'b0, 1'b0, 64'h3333_0000_3333_0003, 32'hA3};
    tbl[6] = '{2'b11, 64'h7777_0000_7777_0007, 32'hB7, 16'd3, 1'b1, 1'b1, 1'b0, 64'h3333_0000_3333_0003, 32'hA3};

    out_mode = 0;
    do_reset();
    check("rst_x", bus.x, 0);
    check("rst_c", bus.c, 0);
    check("rst_flags", {bus.learning_done, bus.learning_recall, bus.mem_load}, 3'b000);
    check("rst_out", {bus.out_valid, bus.out_last}, 2'b00);
    check("rst_counts", {bus.learn_count, bus.recall_count}, 32'h0);
    check("rst_status", {bus.done, bus.error}, 2'b00);
    @(negedge clk);
    check("rst_learn_in_ready", bus.in_ready, 1);
    tick();

    // Learning and SWITCH beats, mem_ready low 2 cycles after each load.
    mem_lat = 2;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        n = 0;
        while (!bus.in_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        tick();
        mem_force_low = 1;
        tick();
        tick();
        @(negedge clk);
        check("switch_ignores_mem_ready", bus.in_ready, 1);
        check("learn_mem_loads", mload_cnt, 3);
        tick();
        mem_force_low = 0;
      end
      send_beat(tbl[i].vec, tbl[i].cls, tbl[i].ctrl, 1'b0, ok);
      check("tbl_learn_count", bus.learn_count, tbl[i].exp_lc);
      check("tbl_learning_done", bus.learning_done, tbl[i].exp_ld);
      check("tbl_learning_recall", bus.learning_recall, tbl[i].exp_lr);
      check("tbl_mem_load", bus.mem_load, tbl[i].exp_ml);
      check("tbl_x", bus.x, tbl[i].exp_x);
      check("tbl_c", bus.c, tbl[i].exp_c);
    end

    // Five recall beats against a depth-4 FIFO with the output stalled.
    for (int i = 0; i < 4; i++) begin
      v = 64'hC0DE_0000_0000_0010 + 64'(i);
      send_beat(v, 32'h0, 2'b00, 1'b0, ok);
      recall_respond(v, 1'b0, i % 3);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.in_ready) bad++;
    end
    check("full_blocks_input", bad, 0);
    check("full_out_valid", bus.out_valid, 1);
    tick();
    out_mode = 1;
    v = 64'hC0DE_0000_0000_0014;
    send_beat(v, 32'h0, 2'b00, 1'b1, ok);
    recall_respond(v, 1'b1, 1);
    wait_done(100);
    check("bp_outputs", pop_cnt, 5);
    check("bp_recall_count", bus.recall_count, 5);
    check("bp_error", bus.error, 0);
    check("bp_x", bus.x, 64'hC0DE_0000_0000_0014);
    check("bp_c", bus.c, 32'hA3);
    check("bp_out_valid", bus.out_valid, 0);

    // Reset with two results pending.
    out_mode = 0;
    do_reset();
    mem_lat = 0;
    send_beat(64'hAB, 32'h77, 2'b01, 1'b0, ok);
    send_beat(64'h0, 32'h0, 2'b11, 1'b0, ok);
    for (int i = 0; i < 2; i++) begin
      v = 64'hFEED_0000_0000_0000 + 64'(i);
      send_beat(v, 32'h0, 2'b00, 1'b0, ok);
      recall_respond(v, 1'b0, 0);
    end
    @(negedge clk);
    check("pending_before_reset", bus.out_valid, 1);
    do_reset();
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_counts", {bus.learn_count, bus.recall_count}, 32'h0);
    check("abort_flags", {bus.learning_done, bus.learning_recall, bus.done}, 3'b000);
    check("abort_x", bus.x, 0);
    @(negedge clk);
    check("abort_learn_in_ready", bus.in_ready, 1);
    tick();

    // Learning beat carrying end-of-message.
    send_beat(64'h1234, 32'h55, 2'b00, 1'b1, ok);
    check("eom_err_status", {bus.error, bus.done}, 2'b11);
    check("eom_err_no_load", {bus.mem_load, bus.learn_count}, 17'h0);
    check("eom_err_x", bus.x, 0);
    out_mode = 1;
    repeat (3) tick();
    @(negedge clk);
    check("eom_err_idle", {bus.out_valid, bus.in_ready, bus.done}, 3'b001);
    tick();

    // Output ready toggling every cycle, then randomized episodes.
    run_episode(3, 1, 8, 3);
    for (int e = 0; e < 6; e++)
      run_episode($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(1, 12),
                  $urandom_range(1, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
